// File: rtl/neuron_if.sv
// Handshake channels of the neuron: forward operands/activation, backward error/gradients,
// plus the per-pass control bits (mode, train).
interface neuron_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
);
    logic                     train;
    logic                     mode;
    logic                     input_forward_valid;
    logic                     input_forward_ready;
    logic [DEPTH*WIDTH-1:0]   input_forward_data;
    logic                     output_forward_valid;
    logic                     output_forward_ready;
    logic [WIDTH-1:0]         output_forward_data;
    logic                     input_backward_valid;
    logic                     input_backward_ready;
    logic [2*WIDTH-1:0]       input_backward_data;
    logic                     output_backward_valid;
    logic                     output_backward_ready;
    logic [DEPTH*2*WIDTH-1:0] output_backward_data;

    modport master (
        output train, mode,
        output input_forward_valid, input_forward_data, output_forward_ready,
        output input_backward_valid, input_backward_data, output_backward_ready,
        input  input_forward_ready, output_forward_valid, output_forward_data,
        input  input_backward_ready, output_backward_valid, output_backward_data
    );

    modport slave (
        input  train, mode,
        input  input_forward_valid, input_forward_data, output_forward_ready,
        input  input_backward_valid, input_backward_data, output_backward_ready,
        output input_forward_ready, output_forward_valid, output_forward_data,
        output input_backward_ready, output_backward_valid, output_backward_data
    );
endinterface

// File: rtl/neuron.sv
// Single trainable neuron: time-multiplexed MAC forward pass with ReLU / hard-sigmoid
// activation and an optional backward pass that emits input gradients and updates weights.
module neuron #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned SCALE = 1
) (
    input logic     clock,
    input logic     reset,
    neuron_if.slave bus_io
);
    localparam int unsigned DW = 2 * WIDTH;
    localparam int unsigned PW = 4 * WIDTH;
    localparam int unsigned EW = 4 * WIDTH + 2;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned IW = $clog2(DEPTH);

    typedef logic signed [DW-1:0] word_t;
    typedef logic signed [EW-1:0] ext_t;

    localparam ext_t One     = ext_t'(1) <<< WIDTH;
    localparam ext_t Half    = One >>> 1;
    localparam ext_t Quarter = One >>> 2;
    localparam ext_t Two1    = One <<< 1;
    localparam ext_t NegTwo1 = -Two1;
    localparam ext_t MaxV    = (ext_t'(1) <<< (DW - 1)) - ext_t'(1);
    localparam ext_t MinV    = -(ext_t'(1) <<< (DW - 1));

    typedef enum logic [2:0] {StIdle, StMac, StAct, StFwd, StDel, StBwd, StOut} state_e;

    state_e                 state_q;
    logic [CW-1:0]          cnt_q;
    word_t                  w_q [DEPTH];
    word_t                  bwd_out_q [DEPTH];
    logic [WIDTH-1:0]       x_q [DEPTH];
    word_t                  b_q, s_q, delta_q, d_q;
    logic                   mode_q;
    logic signed [PW-1:0]   prod_q, upd_q;
    logic [WIDTH-1:0]       a_q;
    logic                   fwd_valid_q, bwd_valid_q;

    function automatic word_t sat(input ext_t v);
        if (v > MaxV) return MaxV[DW-1:0];
        if (v < MinV) return MinV[DW-1:0];
        return v[DW-1:0];
    endfunction

    logic [IW-1:0]        idx, pidx;
    word_t                x_ext, mul_a, mul_b, e_w;
    logic signed [PW-1:0] mul_p, upd_p;
    word_t                mac_sum, grad, w_new, b_new, delta_new, d_next;
    ext_t                 s_e, act_e;
    logic [WIDTH-1:0]     a_next;

    always_comb begin
        idx   = (cnt_q < CW'(DEPTH)) ? IW'(cnt_q) : '0;
        pidx  = IW'(cnt_q - 1'b1);
        x_ext = word_t'({{WIDTH{1'b0}}, x_q[idx]});
        e_w   = bus_io.input_backward_data;
        // One multiplier serves MAC (w*x), delta (e*d) and gradients (w*delta).
        mul_a = w_q[idx];
        mul_b = x_ext;
        if (state_q == StDel) begin
            mul_a = e_w;
            mul_b = d_q;
        end else if (state_q == StBwd) begin
            mul_b = delta_q;
        end
        mul_p = mul_a * mul_b;
        upd_p = delta_q * x_ext;

        mac_sum   = sat(ext_t'(s_q) + ext_t'(prod_q >>> WIDTH));
        grad      = sat(ext_t'(prod_q >>> WIDTH));
        w_new     = sat(ext_t'(w_q[pidx]) + ext_t'(upd_q >>> (WIDTH + SCALE)));
        b_new     = sat(ext_t'(b_q) + ext_t'(delta_q >>> SCALE));
        delta_new = sat(ext_t'(mul_p >>> WIDTH));

        s_e   = ext_t'(s_q);
        act_e = mode_q ? ((s_e >>> 2) + Half) : s_e;
        if (act_e[EW-1])     a_next = '0;
        else if (act_e >= One) a_next = '1;
        else                 a_next = act_e[WIDTH-1:0];
        if (mode_q) d_next = (s_e > NegTwo1 && s_e < Two1) ? Quarter[DW-1:0] : '0;
        else        d_next = (!s_q[DW-1] && s_q != '0 && s_e < One) ? One[DW-1:0] : '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            b_q         <= '0;
            s_q         <= '0;
            delta_q     <= '0;
            d_q         <= '0;
            mode_q      <= 1'b0;
            prod_q      <= '0;
            upd_q       <= '0;
            a_q         <= '0;
            fwd_valid_q <= 1'b0;
            bwd_valid_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                w_q[i]       <= '0;
                x_q[i]       <= '0;
                bwd_out_q[i] <= '0;
            end
        end else begin
            case (state_q)
                StIdle: if (bus_io.input_forward_valid) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        x_q[i] <= bus_io.input_forward_data[i*WIDTH +: WIDTH];
                    end
                    mode_q  <= bus_io.mode;
                    s_q     <= b_q;
                    cnt_q   <= '0;
                    state_q <= StMac;
                end
                StMac: begin
                    // Product of index k is accumulated one cycle later.
                    prod_q <= mul_p;
                    if (cnt_q != '0) s_q <= mac_sum;
                    if (cnt_q == CW'(DEPTH)) state_q <= StAct;
                    else                     cnt_q   <= cnt_q + 1'b1;
                end
                StAct: begin
                    a_q     <= a_next;
                    d_q     <= d_next;
                    state_q <= StFwd;
                end
                StFwd: begin
                    if (!fwd_valid_q) begin
                        fwd_valid_q <= 1'b1;
                    end else if (bus_io.output_forward_ready) begin
                        fwd_valid_q <= 1'b0;
                        state_q     <= bus_io.train ? StDel : StIdle;
                    end
                end
                StDel: if (bus_io.input_backward_valid) begin
                    delta_q <= delta_new;
                    cnt_q   <= '0;
                    state_q <= StBwd;
                end
                StBwd: begin
                    prod_q <= mul_p;
                    upd_q  <= upd_p;
                    // w_i is written one cycle after its gradient product was taken.
                    if (cnt_q == '0) begin
                        b_q <= b_new;
                    end else begin
                        bwd_out_q[pidx] <= grad;
                        w_q[pidx]       <= w_new;
                    end
                    if (cnt_q == CW'(DEPTH)) state_q <= StOut;
                    else                     cnt_q   <= cnt_q + 1'b1;
                end
                StOut: begin
                    if (!bwd_valid_q) begin
                        bwd_valid_q <= 1'b1;
                    end else if (bus_io.output_backward_ready) begin
                        bwd_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus_io.input_forward_ready   = (state_q == StIdle);
    assign bus_io.input_backward_ready  = (state_q == StDel);
    assign bus_io.output_forward_valid  = fwd_valid_q;
    assign bus_io.output_forward_data   = a_q;
    assign bus_io.output_backward_valid = bwd_valid_q;

    for (genvar g = 0; g < DEPTH; g++) begin : gen_bwd_out
        assign bus_io.output_backward_data[g*DW +: DW] = bwd_out_q[g];
    end
endmodule

// File: tb/tb_neuron.sv
// Randomized bench for neuron: a plain-arithmetic reference model predicts activations,
// gradients and weight evolution; a negedge monitor compares every valid output cycle.
module tb_neuron;
    localparam int W  = 8;
    localparam int D  = 2;
    localparam int S  = 1;
    localparam int DW = 2 * W;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    neuron_if #(.WIDTH(W), .DEPTH(D)) bus ();
    neuron #(.WIDTH(W), .DEPTH(D), .SCALE(S)) dut (.clock(clock), .reset(reset), .bus_io(bus));

    int     tests = 0;
    int     fails = 0;
    longint mw [D];
    longint mb;
    longint exp_a;
    longint exp_g [D];
    bit     fwd_armed = 1'b0;
    bit     bwd_armed = 1'b0;
    longint oa, g0, g1;

    function automatic void check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic longint sat(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (bus.output_forward_valid) begin
                check("fwd_expected", longint'(fwd_armed), 1);
                check("fwd_data", longint'(bus.output_forward_data), exp_a);
            end
            if (bus.output_backward_valid) begin
                check("bwd_expected", longint'(bwd_armed), 1);
                for (int i = 0; i < D; i++) begin
                    check("bwd_data", longint'($signed(bus.output_backward_data[i*DW +: DW])),
                          exp_g[i]);
                end
            end
        end
    end

    task automatic garbage();
        bus.input_forward_valid  = 1'($urandom);
        bus.input_forward_data   = (D*W)'($urandom);
        bus.input_backward_valid = 1'($urandom);
        bus.input_backward_data  = DW'($urandom);
        bus.mode                 = 1'($urandom);
    endtask

    task automatic quiet();
        bus.input_forward_valid  = 1'b0;
        bus.input_backward_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        quiet();
        bus.output_forward_ready  = 1'b0;
        bus.output_backward_ready = 1'b0;
        step();
        check("rst_fwd_valid", longint'(bus.output_forward_valid), 0);
        check("rst_bwd_valid", longint'(bus.output_backward_valid), 0);
        check("rst_fwd_ready", longint'(bus.input_forward_ready), 1);
        check("rst_bwd_ready", longint'(bus.input_backward_ready), 0);
        reset = 1'b0;
        for (int i = 0; i < D; i++) mw[i] = 0;
        mb = 0;
        fwd_armed = 1'b0;
        bwd_armed = 1'b0;
    endtask

    task automatic run_pass(input logic [D*W-1:0] xv, input logic md, input logic tr,
                            input logic signed [DW-1:0] e, input int hold, input bit abort_out,
                            output longint a_o, output longint g0_o, output longint g1_o);
        longint s, act, d, delta, xi;
        int     n;
        g0_o = 0;
        g1_o = 0;
        bus.input_forward_data  = xv;
        bus.mode                = md;
        bus.input_forward_valid = 1'b1;
        check("fwd_in_ready", longint'(bus.input_forward_ready), 1);
        step();
        quiet();
        s = mb;
        for (int i = 0; i < D; i++) begin
            xi = longint'(xv[i*W +: W]);
            s  = sat(s + ((mw[i] * xi) >>> W));
        end
        if (md == 1'b0) begin
            act = s;
            d   = (s > 0 && s < 256) ? 256 : 0;
        end else begin
            act = (s >>> 2) + 128;
            d   = (s > -512 && s < 512) ? 64 : 0;
        end
        exp_a     = (act < 0) ? 0 : (act > 255) ? 255 : act;
        fwd_armed = 1'b1;
        n = 0;
        while (!bus.output_forward_valid && n < 40) begin
            garbage();
            step();
            n++;
        end
        quiet();
        check("fwd_latency", n, D + 3);
        a_o = longint'(bus.output_forward_data);
        for (int k = 0; k < hold; k++) begin
            check("fwd_held_valid", longint'(bus.output_forward_valid), 1);
            check("fwd_busy_ready", longint'(bus.input_forward_ready), 0);
            garbage();
            step();
        end
        quiet();
        bus.train                = tr;
        bus.output_forward_ready = 1'b1;
        step();
        bus.output_forward_ready = 1'b0;
        fwd_armed = 1'b0;
        if (!tr) begin
            check("idle_after_fwd", longint'(bus.input_forward_ready), 1);
            return;
        end
        check("bwd_in_ready", longint'(bus.input_backward_ready), 1);
        delta = sat((longint'(e) * d) >>> W);
        for (int i = 0; i < D; i++) begin
            xi       = longint'(xv[i*W +: W]);
            exp_g[i] = sat((mw[i] * delta) >>> W);
            mw[i]    = sat(mw[i] + ((delta * xi) >>> (W + S)));
        end
        mb = sat(mb + (delta >>> S));
        bus.input_backward_data  = e;
        bus.input_backward_valid = 1'b1;
        step();
        quiet();
        bwd_armed = 1'b1;
        n = 0;
        while (!bus.output_backward_valid && n < 40) begin
            garbage();
            step();
            n++;
        end
        quiet();
        check("bwd_latency", n, D + 2);
        g0_o = longint'($signed(bus.output_backward_data[0 +: DW]));
        g1_o = longint'($signed(bus.output_backward_data[DW +: DW]));
        if (abort_out) return;
        bus.output_backward_ready = 1'b1;
        step();
        bus.output_backward_ready = 1'b0;
        bwd_armed = 1'b0;
        check("idle_after_bwd", longint'(bus.input_forward_ready), 1);
    endtask

    initial begin
        bus.train = 1'b0;
        bus.mode  = 1'b0;
        bus.input_forward_data    = '0;
        bus.input_backward_data   = '0;
        bus.output_forward_ready  = 1'b0;
        bus.output_backward_ready = 1'b0;
        quiet();
        step();
        step();
        do_reset();

        // Forward only, hard sigmoid then ReLU with a long output stall.
        run_pass({8'd64, 8'd128}, 1'b1, 1'b0, 16'sd0, 0, 1'b0, oa, g0, g1);
        check("sig_zero_out", oa, 128);
        run_pass({8'd64, 8'd128}, 1'b0, 1'b0, 16'sd0, 10, 1'b0, oa, g0, g1);
        check("relu_zero_out", oa, 0);

        // One training step, then observe the learned weights through the forward path.
        run_pass({8'd64, 8'd128}, 1'b1, 1'b1, 16'sd256, 1, 1'b0, oa, g0, g1);
        check("train_grad0", g0, 0);
        check("train_grad1", g1, 0);
        check("model_w0", mw[0], 16);
        check("model_w1", mw[1], 8);
        check("model_b", mb, 32);
        run_pass({8'd64, 8'd128}, 1'b0, 1'b0, 16'sd0, 0, 1'b0, oa, g0, g1);
        check("relu_trained_out", oa, 42);

        // Reset while the backward result is being offered.
        run_pass({8'd64, 8'd128}, 1'b1, 1'b1, 16'sd256, 0, 1'b1, oa, g0, g1);
        check("sig_trained_out", oa, 138);
        check("trained_grad0", g0, 4);
        check("trained_grad1", g1, 2);
        do_reset();
        run_pass({8'd64, 8'd128}, 1'b1, 1'b0, 16'sd0, 0, 1'b0, oa, g0, g1);
        check("after_out_reset", oa, 128);

        // Reset in the middle of the MAC phase after training moved the weights.
        run_pass({8'd64, 8'd128}, 1'b1, 1'b1, 16'sd256, 0, 1'b0, oa, g0, g1);
        bus.input_forward_data  = {8'd64, 8'd128};
        bus.mode                = 1'b1;
        bus.input_forward_valid = 1'b1;
        step();
        quiet();
        step();
        do_reset();
        run_pass({8'd64, 8'd128}, 1'b1, 1'b0, 16'sd0, 0, 1'b0, oa, g0, g1);
        check("after_mac_reset", oa, 128);

        // Push the bias far positive: activation clips and the derivative vanishes.
        do_reset();
        run_pass({8'd0, 8'd0}, 1'b1, 1'b1, 16'sd32767, 0, 1'b0, oa, g0, g1);
        check("bias_push_out", oa, 128);
        check("model_b_big", mb, 4095);
        run_pass({8'd64, 8'd128}, 1'b1, 1'b1, 16'sd256, 0, 1'b0, oa, g0, g1);
        check("sig_clip_out", oa, 255);
        check("dead_grad0", g0, 0);
        check("dead_grad1", g1, 0);
        run_pass({8'd0, 8'd0}, 1'b0, 1'b0, 16'sd0, 0, 1'b0, oa, g0, g1);
        check("bias_kept_out", oa, 255);

        do_reset();
        for (int k = 0; k < 60; k++) begin
            logic signed [DW-1:0] e;
            if ($urandom_range(0, 3) == 0) e = DW'($urandom);
            else                           e = DW'(int'($urandom_range(0, 2047)) - 1024);
            run_pass((D*W)'($urandom), 1'($urandom), 1'($urandom), e,
                     int'($urandom_range(0, 3)), 1'b0, oa, g0, g1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
